// File: rtl/miller_mod_encoder.sv
// ISO 14443A 106 kbit/s reader-to-card modified Miller transmit encoder.
// Optional odd parity ETU after each byte is compiled in with `define MILLER_TX_PARITY_EN.
module miller_mod_encoder #(
    parameter int unsigned ETU_CLKS   = 32,
    parameter int unsigned PAUSE_CLKS = 8
) (
    input  logic       in_clk,
    input  logic       in_PoR,
    input  logic [7:0] in_tx_data,
    input  logic       in_tx_valid,
    input  logic       in_tx_last,
    output logic       out_tx_ready,
    output logic       out_data,
    output logic       out_busy,
    output logic       out_eof_done,
    output logic       out_underrun
);

    localparam int unsigned CNT_W = (ETU_CLKS > 1) ? $clog2(ETU_CLKS) : 1;
    localparam int unsigned BIT_W = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ETU_CLKS - 1);
    localparam logic [CNT_W-1:0] Z_END    = CNT_W'(PAUSE_CLKS);
    localparam logic [CNT_W-1:0] X_BEGIN  = CNT_W'(ETU_CLKS / 2);
    localparam logic [CNT_W-1:0] X_END    = CNT_W'(ETU_CLKS / 2 + PAUSE_CLKS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
`ifdef MILLER_TX_PARITY_EN
        S_PARITY,
`endif
        S_EOF0,
        S_EOFY
    } state_t;

    // Pause pattern carried by the current ETU.
    typedef enum logic [1:0] {
        SEQ_Y = 2'd0,
        SEQ_X = 2'd1,
        SEQ_Z = 2'd2
    } seq_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       byte_q, byte_d;
    logic             last_q, last_d;
    logic             prev_zero_q, prev_zero_d;
    seq_t             seq_q, seq_d;

    logic tx_ready_d, data_d, busy_d, eof_done_d, underrun_d;
    logic cnt_end, byte_end, accept_idle, accept_bnd, ready_bnd_next;

    function automatic seq_t code_bit(input logic b, input logic pz);
        code_bit = b ? SEQ_X : (pz ? SEQ_Z : SEQ_Y);
    endfunction

    function automatic logic pause_at(input seq_t s, input logic [CNT_W-1:0] c);
        case (s)
            SEQ_Z:   pause_at = (c < Z_END);
            SEQ_X:   pause_at = (c >= X_BEGIN) && (c < X_END);
            default: pause_at = 1'b0;
        endcase
    endfunction

    assign cnt_end = (cnt_q == CNT_LAST);

    // Final cycle of the last ETU belonging to the current byte.
`ifdef MILLER_TX_PARITY_EN
    assign byte_end = (state_q == S_PARITY) && cnt_end;
`else
    assign byte_end = (state_q == S_DATA) && (bit_q == BIT_LAST) && cnt_end;
`endif

    assign accept_idle = (state_q == S_IDLE) && in_tx_valid && out_tx_ready;
    assign accept_bnd  = byte_end && in_tx_valid && out_tx_ready;

    // State register and registered outputs.
    always_ff @(posedge in_clk or negedge in_PoR) begin
        if (!in_PoR) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            last_q       <= 1'b0;
            prev_zero_q  <= 1'b0;
            seq_q        <= SEQ_Y;
            out_tx_ready <= 1'b0;
            out_data     <= 1'b1;
            out_busy     <= 1'b0;
            out_eof_done <= 1'b0;
            out_underrun <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            prev_zero_q  <= prev_zero_d;
            seq_q        <= seq_d;
            out_tx_ready <= tx_ready_d;
            out_data     <= data_d;
            out_busy     <= busy_d;
            out_eof_done <= eof_done_d;
            out_underrun <= underrun_d;
        end
    end

    // Next-state: sequencing, bit selection and coding of the next ETU.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        last_d      = last_q;
        prev_zero_d = prev_zero_q;
        seq_d       = seq_q;

        if (state_q != S_IDLE) begin
            cnt_d = cnt_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept_idle) begin
                    byte_d      = in_tx_data;
                    last_d      = in_tx_last;
                    cnt_d       = '0;
                    state_d     = S_SOF;
                    seq_d       = SEQ_Z;
                    prev_zero_d = 1'b1;
                end
            end
            S_SOF: begin
                if (cnt_end) begin
                    state_d     = S_DATA;
                    bit_d       = '0;
                    seq_d       = code_bit(byte_q[0], prev_zero_q);
                    prev_zero_d = ~byte_q[0];
                end
            end
            S_DATA: begin
                if (cnt_end && (bit_q != BIT_LAST)) begin
                    bit_d       = bit_q + BIT_W'(1);
                    seq_d       = code_bit(byte_q[bit_q + BIT_W'(1)], prev_zero_q);
                    prev_zero_d = ~byte_q[bit_q + BIT_W'(1)];
                end
`ifdef MILLER_TX_PARITY_EN
                else if (cnt_end) begin
                    state_d     = S_PARITY;
                    seq_d       = code_bit(~^byte_q, prev_zero_q);
                    prev_zero_d = ^byte_q;
                end
`endif
            end
`ifdef MILLER_TX_PARITY_EN
            S_PARITY: begin
                // Byte boundary handled below.
            end
`endif
            S_EOF0: begin
                if (cnt_end) begin
                    state_d = S_EOFY;
                    seq_d   = SEQ_Y;
                end
            end
            S_EOFY: begin
                if (cnt_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Byte boundary: chain the next byte with no gap, or close the frame.
        if (byte_end) begin
            if (accept_bnd) begin
                byte_d      = in_tx_data;
                last_d      = in_tx_last;
                state_d     = S_DATA;
                bit_d       = '0;
                seq_d       = code_bit(in_tx_data[0], prev_zero_q);
                prev_zero_d = ~in_tx_data[0];
            end else begin
                state_d     = S_EOF0;
                seq_d       = code_bit(1'b0, prev_zero_q);
                prev_zero_d = 1'b1;
            end
        end
    end

    // Outputs are computed from next-state values so the registers line up with the counter.
`ifdef MILLER_TX_PARITY_EN
    assign ready_bnd_next = (state_d == S_PARITY) && (cnt_d == CNT_LAST) && !last_d;
`else
    assign ready_bnd_next = (state_d == S_DATA) && (bit_d == BIT_LAST) &&
                            (cnt_d == CNT_LAST) && !last_d;
`endif

    always_comb begin
        tx_ready_d = 1'b0;
        data_d     = 1'b1;
        busy_d     = 1'b0;
        eof_done_d = 1'b0;
        underrun_d = 1'b0;

        tx_ready_d = (state_d == S_IDLE) || ready_bnd_next;
        busy_d     = (state_d != S_IDLE);
        if (state_d != S_IDLE) begin
            data_d = ~pause_at(seq_d, cnt_d);
        end
        eof_done_d = (state_d == S_EOFY) && (cnt_d == CNT_LAST);
        underrun_d = byte_end && !last_q && !accept_bnd;
    end

    a_ready_window: assert property (@(posedge in_clk) disable iff (!in_PoR)
        out_tx_ready |-> ((state_q == S_IDLE) || byte_end));

    a_busy_state: assert property (@(posedge in_clk) disable iff (!in_PoR)
        out_busy == (state_q != S_IDLE));

endmodule

// File: tb/tb_miller_mod_encoder.sv
// Scoreboard bench for miller_mod_encoder: per-cycle expected line state built from a symbol model.
module tb_miller_mod_encoder;

    localparam int ETU   = 32;
    localparam int PAUSE = 8;
`ifdef MILLER_TX_PARITY_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif

    logic       in_clk = 1'b0;
    logic       in_PoR;
    logic [7:0] in_tx_data;
    logic       in_tx_valid;
    logic       in_tx_last;
    logic       out_tx_ready;
    logic       out_data;
    logic       out_busy;
    logic       out_eof_done;
    logic       out_underrun;

    typedef struct packed {
        logic data;
        logic busy;
        logic ready;
        logic eof;
        logic und;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] fr_bytes[$];
    logic       fr_last;
    int         checks   = 0;
    int         failures = 0;

    miller_mod_encoder #(.ETU_CLKS(ETU), .PAUSE_CLKS(PAUSE)) dut (
        .in_clk      (in_clk),
        .in_PoR      (in_PoR),
        .in_tx_data  (in_tx_data),
        .in_tx_valid (in_tx_valid),
        .in_tx_last  (in_tx_last),
        .out_tx_ready(out_tx_ready),
        .out_data    (out_data),
        .out_busy    (out_busy),
        .out_eof_done(out_eof_done),
        .out_underrun(out_underrun)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // Symbols: 0 = Y, 1 = X, 2 = Z. Cycle k=1 is the first cycle after acceptance.
    task automatic build_expected();
        int   syms[$];
        int   ready_k[$];
        int   und_k;
        int   frame_len;
        bit   pz;
        bit   b;
        exp_t e;
        syms.push_back(2);
        pz = 1'b1;
        for (int j = 0; j < fr_bytes.size(); j++) begin
            for (int i = 0; i < 8; i++) begin
                b = fr_bytes[j][i];
                syms.push_back(b ? 1 : (pz ? 2 : 0));
                pz = !b;
            end
`ifdef MILLER_TX_PARITY_EN
            b = ~^fr_bytes[j];
            syms.push_back(b ? 1 : (pz ? 2 : 0));
            pz = !b;
`endif
            if (!((j == fr_bytes.size() - 1) && fr_last)) ready_k.push_back(syms.size() * ETU);
        end
        und_k = fr_last ? -1 : ready_k[ready_k.size() - 1] + 1;
        syms.push_back(pz ? 2 : 0);
        syms.push_back(0);
        frame_len = syms.size() * ETU;
        for (int k = 1; k <= frame_len; k++) begin
            int s;
            int c;
            s = syms[(k - 1) / ETU];
            c = (k - 1) % ETU;
            if (s == 2)      e.data = (c >= PAUSE);
            else if (s == 1) e.data = !((c >= ETU / 2) && (c < ETU / 2 + PAUSE));
            else             e.data = 1'b1;
            e.busy  = 1'b1;
            e.ready = 1'b0;
            foreach (ready_k[r]) if (ready_k[r] == k) e.ready = 1'b1;
            e.eof = (k == frame_len);
            e.und = (k == und_k);
            sb_q.push_back(e);
        end
        for (int k = 0; k < 3; k++) begin
            e.data = 1'b1; e.busy = 1'b0; e.ready = 1'b1; e.eof = 1'b0; e.und = 1'b0;
            sb_q.push_back(e);
        end
    endtask

    task automatic run_frame(input bit noise, input string name);
        int   idx;
        int   accepted;
        int   busy_cnt;
        int   k;
        int   cyc;
        int   exp_len;
        bit   acc_pending;
        exp_t e;
        exp_t o;
        sb_q.delete();
        build_expected();
        exp_len = (3 + BPB * fr_bytes.size()) * ETU;
        @(negedge in_clk);
        in_tx_data  = fr_bytes[0];
        in_tx_last  = (fr_bytes.size() == 1) && fr_last;
        in_tx_valid = 1'b1;
        k = 0;
        while (out_tx_ready !== 1'b1 && k < 20) begin
            @(negedge in_clk);
            k++;
        end
        checks++;
        if (out_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_start ready=%b required=1", name, out_tx_ready);
            in_tx_valid = 1'b0;
            return;
        end
        idx = 1; accepted = 1; busy_cnt = 0; cyc = 0; acc_pending = 1'b0;
        while (sb_q.size() > 0) begin
            @(negedge in_clk);
            cyc++;
            e = sb_q.pop_front();
            if (acc_pending) begin
                idx++;
                accepted++;
            end
            if (idx < fr_bytes.size()) begin
                if (noise && !e.ready) begin
                    in_tx_valid = 1'($urandom_range(0, 1));
                    in_tx_data  = 8'($urandom);
                    in_tx_last  = 1'($urandom_range(0, 1));
                end else begin
                    in_tx_valid = 1'b1;
                    in_tx_data  = fr_bytes[idx];
                    in_tx_last  = (idx == fr_bytes.size() - 1) && fr_last;
                end
            end else if (noise && e.busy && !e.ready) begin
                in_tx_valid = 1'($urandom_range(0, 1));
                in_tx_data  = 8'($urandom);
                in_tx_last  = 1'($urandom_range(0, 1));
            end else begin
                in_tx_valid = 1'b0;
            end
            o.data = out_data; o.busy = out_busy; o.ready = out_tx_ready;
            o.eof = out_eof_done; o.und = out_underrun;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s_cycle%0d data/busy/ready/eof/und got=%b required=%b",
                         name, cyc, o, e);
            end
            if (out_busy === 1'b1) busy_cnt++;
            acc_pending = (out_tx_ready === 1'b1) && (in_tx_valid === 1'b1) && e.busy;
        end
        in_tx_valid = 1'b0;
        checks++;
        if (accepted !== fr_bytes.size()) begin
            failures++;
            $display("FAIL %s_accepted got=%0d required=%0d", name, accepted, fr_bytes.size());
        end
        checks++;
        if (busy_cnt !== exp_len) begin
            failures++;
            $display("FAIL %s_frame_len got=%0d required=%0d", name, busy_cnt, exp_len);
        end
    endtask

    task automatic test_reset();
        exp_t o;
        #12;
        o.data = out_data; o.busy = out_busy; o.ready = out_tx_ready;
        o.eof = out_eof_done; o.und = out_underrun;
        checks++;
        if (o !== 5'b10000) begin
            failures++;
            $display("FAIL reset_held got=%b required=%b", o, 5'b10000);
        end
        repeat (3) @(negedge in_clk);
        in_PoR = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge in_clk);
            o.data = out_data; o.busy = out_busy; o.ready = out_tx_ready;
            o.eof = out_eof_done; o.und = out_underrun;
            checks++;
            if (o !== 5'b10100) begin
                failures++;
                $display("FAIL reset_idle%0d got=%b required=%b", i, o, 5'b10100);
            end
        end
    endtask

    task automatic test_single_zero();
        fr_bytes.delete(); fr_bytes.push_back(8'h00); fr_last = 1'b1;
        run_frame(1'b0, "byte00");
    endtask

    task automatic test_single_one();
        fr_bytes.delete(); fr_bytes.push_back(8'h01); fr_last = 1'b1;
        run_frame(1'b0, "byte01");
    endtask

    task automatic test_back_to_back();
        fr_bytes.delete(); fr_bytes.push_back(8'hFF); fr_bytes.push_back(8'hA5); fr_last = 1'b1;
        run_frame(1'b0, "b2b");
    endtask

    task automatic test_underrun();
        fr_bytes.delete(); fr_bytes.push_back(8'h12); fr_last = 1'b0;
        run_frame(1'b0, "underrun");
    endtask

    task automatic test_ignore_not_ready();
        fr_bytes.delete();
        fr_bytes.push_back(8'h3C); fr_bytes.push_back(8'h81); fr_bytes.push_back(8'h00);
        fr_last = 1'b1;
        run_frame(1'b1, "noise");
    endtask

    task automatic test_reset_mid();
        int k;
        int eofs;
        @(negedge in_clk);
        in_tx_data = 8'h55; in_tx_last = 1'b1; in_tx_valid = 1'b1;
        k = 0;
        while (out_tx_ready !== 1'b1 && k < 20) begin
            @(negedge in_clk);
            k++;
        end
        @(negedge in_clk);
        in_tx_valid = 1'b0;
        repeat (100) @(negedge in_clk);
        checks++;
        if (out_busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy_before got=%b required=1", out_busy);
        end
        #2 in_PoR = 1'b0;
        #1;
        checks++;
        if ({out_data, out_busy, out_tx_ready} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_async data/busy/ready got=%b required=100",
                     {out_data, out_busy, out_tx_ready});
        end
        eofs = 0;
        repeat (4) begin
            @(negedge in_clk);
            if (out_eof_done === 1'b1) eofs++;
        end
        in_PoR = 1'b1;
        repeat (400) begin
            @(negedge in_clk);
            if (out_eof_done === 1'b1) eofs++;
        end
        checks++;
        if (eofs !== 0) begin
            failures++;
            $display("FAIL rstmid_eof_done got=%0d required=0", eofs);
        end
        checks++;
        if ({out_data, out_busy, out_tx_ready} !== 3'b101) begin
            failures++;
            $display("FAIL rstmid_idle data/busy/ready got=%b required=101",
                     {out_data, out_busy, out_tx_ready});
        end
        fr_bytes.delete(); fr_bytes.push_back(8'hC3); fr_last = 1'b1;
        run_frame(1'b0, "after_reset");
    endtask

    initial begin
        in_PoR      = 1'b0;
        in_tx_data  = 8'h00;
        in_tx_valid = 1'b0;
        in_tx_last  = 1'b0;
        test_reset();
        test_single_zero();
        test_single_one();
        test_back_to_back();
        test_underrun();
        test_ignore_not_ready();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
